// File: rtl/cntr_readout_arbiter_if.sv
// -----------------------------------------------------------------------------
// cntr_readout_arbiter_if
//
// Bundles the counter-sample inputs and the processor readout path of
// cntr_readout_arbiter.
//
//   slave  modport : the arbiter itself
//   master modport : the counter channels plus the processor side
//
// Signals
//   cntr_in        N_CH*CW  packed counts, channel c at [c*CW +: CW]
//   cntr_valid     N_CH     per-channel one-cycle sample strobe
//   data_out       32       FIFO head word, 0 when empty
//   data_out_valid 1        FIFO non-empty
//   data_out_read  1        pop request, level-sensitive
//   ovr            N_CH     sticky per-channel overrun flags
//   ovr_clr        1        clears all ovr bits
//   level          log2(DEPTH)+1  FIFO occupancy
// -----------------------------------------------------------------------------
interface cntr_readout_arbiter_if #(
  parameter int N_CH  = 3,
  parameter int CW    = 10,
  parameter int DEPTH = 4
);
  logic [N_CH*CW-1:0]      cntr_in;
  logic [N_CH-1:0]         cntr_valid;
  logic [31:0]             data_out;
  logic                    data_out_valid;
  logic                    data_out_read;
  logic [N_CH-1:0]         ovr;
  logic                    ovr_clr;
  logic [$clog2(DEPTH):0]  level;

  modport slave (
    input  cntr_in, cntr_valid, data_out_read, ovr_clr,
    output data_out, data_out_valid, ovr, level
  );

  modport master (
    output cntr_in, cntr_valid, data_out_read, ovr_clr,
    input  data_out, data_out_valid, ovr, level
  );
endinterface

// File: rtl/cntr_readout_arbiter.sv
// -----------------------------------------------------------------------------
// cntr_readout_arbiter
//
// Shares one 32-bit readout path between N_CH time-difference counter
// channels. Each channel has a one-deep holding register; pending channels are
// granted round-robin into a DEPTH-word FIFO that the processor drains.
//
// Output word: [31] overrun tag, [30:24] sequence number, [23:16] channel,
//              [15:CW] zero, [CW-1:0] count.
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   cntr_readout_arbiter_if.slave (samples in, readout out)
// -----------------------------------------------------------------------------
module cntr_readout_arbiter #(
  parameter int N_CH  = 3,
  parameter int CW    = 10,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  cntr_readout_arbiter_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Per-channel holding registers
  logic [CW-1:0]   hold_q [N_CH];
  logic [CW-1:0]   hold_d [N_CH];
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] tag_q,  tag_d;   // overrun tag of the pending sample
  logic [N_CH-1:0] ovr_q,  ovr_d;

  // Arbiter state
  logic [6:0]      seq_q, seq_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  // FIFO
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [LW-1:0]   level_q, level_d;

  logic            full;
  logic            push;
  logic            pop;
  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic [31:0]     word;

  assign full = (level_q == LW'(DEPTH));
  assign push = gnt_vld;
  assign pop  = (level_q != '0) && bus.data_out_read;

  // Round-robin search starting one past the last granted channel.
  // NOTE: every variable written in an always_comb gets a default first so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_vld && pend_q[idx[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[PW-1:0];
      end
    end
    // A full FIFO stalls arbitration; pending samples simply wait.
    if (full) gnt_vld = 1'b0;
  end

  always_comb begin
    word          = '0;
    word[CW-1:0]  = hold_q[gnt_idx];
    word[23:16]   = 8'(gnt_idx);
    word[30:24]   = seq_q;
    word[31]      = tag_q[gnt_idx];
  end

  // Capture and overrun detection. A valid on the channel being granted this
  // cycle is a hand-over (old value leaves, new value waits), not an overrun.
  always_comb begin
    logic gnt_c;
    hold_d = hold_q;
    pend_d = pend_q;
    tag_d  = tag_q;
    ovr_d  = bus.ovr_clr ? '0 : ovr_q;
    gnt_c  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      gnt_c = gnt_vld && (gnt_idx == PW'(c));
      if (bus.cntr_valid[c]) begin
        hold_d[c] = bus.cntr_in[c*CW +: CW];
        pend_d[c] = 1'b1;
        if (pend_q[c] && !gnt_c) begin
          tag_d[c] = 1'b1;
          ovr_d[c] = 1'b1;   // set after the clear so a new overrun wins
        end else begin
          tag_d[c] = 1'b0;
        end
      end else if (gnt_c) begin
        pend_d[c] = 1'b0;
        tag_d[c]  = 1'b0;
      end
    end
  end

  // Arbiter pointer, sequence counter and FIFO bookkeeping
  always_comb begin
    ptr_d   = push ? gnt_idx : ptr_q;
    seq_d   = push ? seq_q + 7'd1 : seq_q;       // wraps 127 -> 0
    wr_d    = push ? wr_q + 1'b1 : wr_q;         // wraps modulo DEPTH
    rd_d    = pop  ? rd_q + 1'b1 : rd_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) hold_q[c] <= '0;
      pend_q  <= '0;
      tag_q   <= '0;
      ovr_q   <= '0;
      seq_q   <= '0;
      ptr_q   <= PW'(N_CH - 1);   // channel 0 has first priority
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      tag_q   <= tag_d;
      ovr_q   <= ovr_d;
      seq_q   <= seq_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; reset empties the FIFO via
  // level/pointers and data_out is masked to 0 while empty, so stale entries
  // are never observable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= word;
  end

  assign bus.data_out       = (level_q != '0) ? mem_q[rd_q] : '0;
  assign bus.data_out_valid = (level_q != '0);
  assign bus.ovr            = ovr_q;
  assign bus.level          = level_q;

endmodule

// File: tb/tb_cntr_readout_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cntr_readout_arbiter
//
// Directed stimulus with hand-computed expected words. Stimulus pushes each
// expected word into a scoreboard queue; an independent monitor pops and
// compares whenever the DUT pops a word (data_out_valid & data_out_read).
// -----------------------------------------------------------------------------
module tb_cntr_readout_arbiter;

  localparam int N_CH  = 3;
  localparam int CW    = 10;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  cntr_readout_arbiter_if #(.N_CH(N_CH), .CW(CW), .DEPTH(DEPTH)) bus ();

  cntr_readout_arbiter #(.N_CH(N_CH), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests_run;
  int tests_failed;
  logic [31:0] sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every word the DUT actually hands out.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.data_out_valid && bus.data_out_read) begin
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_word: got 0x%08h, expected no word",
                   bus.data_out);
        end else begin
          check("word", bus.data_out, sb.pop_front());
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ch(input int c, input logic [CW-1:0] v);
    bus.cntr_in[c*CW +: CW] = v;
    bus.cntr_valid[c]       = 1'b1;
  endtask

  task automatic clr_valid();
    bus.cntr_valid = '0;
  endtask

  function automatic logic [31:0] mk(input logic tag, input logic [6:0] seq,
                                     input logic [7:0] ch, input logic [CW-1:0] v);
    logic [31:0] w;
    w = '0;
    w[31]     = tag;
    w[30:24]  = seq;
    w[23:16]  = ch;
    w[CW-1:0] = v;
    return w;
  endfunction

  task automatic do_reset();
    rst               = 1'b0;
    bus.cntr_in       = '0;
    bus.cntr_valid    = '0;
    bus.data_out_read = 1'b0;
    bus.ovr_clr       = 1'b0;
    sb.delete();
    ticks(2);
    check("rst_valid", 32'(bus.data_out_valid), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_data",  bus.data_out, 32'd0);
    check("rst_ovr",   32'(bus.ovr), 32'd0);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;

    // ---- single sample, 2-edge latency -------------------------------------
    do_reset();
    set_ch(0, 10'd800);
    tick();
    clr_valid();
    check("t1_level_after_capture", 32'(bus.level), 32'd0);
    tick();
    check("t1_valid", 32'(bus.data_out_valid), 32'd1);
    check("t1_level", 32'(bus.level), 32'd1);
    check("t1_head",  bus.data_out, 32'h0000_0320);
    sb.push_back(32'h0000_0320);
    bus.data_out_read = 1'b1;
    tick();
    bus.data_out_read = 1'b0;
    check("t1_empty_level", 32'(bus.level), 32'd0);
    check("t1_empty_data",  bus.data_out, 32'd0);
    check("t1_empty_valid", 32'(bus.data_out_valid), 32'd0);

    // ---- three simultaneous valids, round-robin order ----------------------
    do_reset();
    set_ch(0, 10'd800);
    set_ch(1, 10'd200);
    set_ch(2, 10'd5);
    tick();
    clr_valid();
    ticks(3);
    check("t2_level", 32'(bus.level), 32'd3);
    sb.push_back(32'h0000_0320);
    sb.push_back(32'h0101_00C8);
    sb.push_back(32'h0202_0005);
    bus.data_out_read = 1'b1;
    ticks(3);
    bus.data_out_read = 1'b0;
    check("t2_drained", 32'(bus.level), 32'd0);

    // ---- FIFO full and overrun on ch1 --------------------------------------
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_ch(1, (i % 2 == 0) ? 10'd200 : 10'd800);
      tick();
    end
    clr_valid();
    check("t3_full_level", 32'(bus.level), 32'd4);
    check("t3_ovr", 32'(bus.ovr), 32'b010);
    sb.push_back(32'h0001_00C8);
    sb.push_back(32'h0101_0320);
    sb.push_back(32'h0201_00C8);
    sb.push_back(32'h0301_0320);
    sb.push_back(32'h8401_0320);
    bus.data_out_read = 1'b1;
    tick();
    bus.data_out_read = 1'b0;
    check("t3_after_pop", 32'(bus.level), 32'd3);
    tick();
    check("t3_refill", 32'(bus.level), 32'd4);
    bus.data_out_read = 1'b1;
    ticks(4);
    bus.data_out_read = 1'b0;
    check("t3_drained", 32'(bus.level), 32'd0);

    // ---- streaming with read held high, seq wraps past 127 -----------------
    do_reset();
    bus.data_out_read = 1'b1;
    for (int i = 0; i < 136; i++) begin
      logic [CW-1:0] v;
      v = (i % 2 == 0) ? 10'd200 : 10'd800;
      set_ch(0, v);
      sb.push_back(mk(1'b0, 7'(i), 8'd0, v));
      tick();
    end
    clr_valid();
    ticks(3);
    bus.data_out_read = 1'b0;
    check("t4_level", 32'(bus.level), 32'd0);
    check("t4_valid", 32'(bus.data_out_valid), 32'd0);
    check("t4_ovr",   32'(bus.ovr), 32'd0);

    // ---- valid/grant collision on ch2, ovr_clr behaviour -------------------
    do_reset();
    set_ch(2, 10'd5);
    tick();
    clr_valid();
    set_ch(2, 10'd7);
    set_ch(0, 10'd3);
    set_ch(1, 10'd4);
    tick();
    clr_valid();
    set_ch(1, 10'd6);
    tick();
    clr_valid();
    check("t5_ovr_set", 32'(bus.ovr), 32'b010);
    ticks(2);
    check("t5_level", 32'(bus.level), 32'd4);
    sb.push_back(32'h0002_0005);
    sb.push_back(32'h0100_0003);
    sb.push_back(32'h8201_0006);
    sb.push_back(32'h0302_0007);
    bus.data_out_read = 1'b1;
    ticks(4);
    bus.data_out_read = 1'b0;
    check("t5_ovr_ch2_clear", 32'(bus.ovr), 32'b010);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    check("t5_ovr_cleared", 32'(bus.ovr), 32'd0);
    set_ch(0, 10'd1);
    set_ch(1, 10'd2);
    tick();
    clr_valid();
    set_ch(1, 10'd3);
    bus.ovr_clr = 1'b1;
    tick();
    clr_valid();
    bus.ovr_clr = 1'b0;
    check("t5_ovr_wins_clr", 32'(bus.ovr), 32'b010);
    tick();
    sb.push_back(32'h0400_0001);
    sb.push_back(32'h8501_0003);
    bus.data_out_read = 1'b1;
    ticks(2);
    bus.data_out_read = 1'b0;
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    check("t5_ovr_final", 32'(bus.ovr), 32'd0);

    // ---- reset mid-operation -----------------------------------------------
    do_reset();
    set_ch(0, 10'd1);
    set_ch(1, 10'd2);
    set_ch(2, 10'd3);
    tick();
    clr_valid();
    ticks(3);
    set_ch(1, 10'd4);
    set_ch(2, 10'd5);
    tick();
    clr_valid();
    check("t6_level_before", 32'(bus.level), 32'd3);
    rst = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.data_out_valid), 32'd0);
    check("t6_async_level", 32'(bus.level), 32'd0);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();
    set_ch(0, 10'd9);
    set_ch(2, 10'd8);
    tick();
    clr_valid();
    ticks(2);
    check("t6_level_after", 32'(bus.level), 32'd2);
    sb.push_back(32'h0000_0009);
    sb.push_back(32'h0102_0008);
    bus.data_out_read = 1'b1;
    ticks(3);
    bus.data_out_read = 1'b0;
    check("t6_drained_valid", 32'(bus.data_out_valid), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
